dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake.
- Performs byte, half or word reads and writes after a configurable number of wait states, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency data memory so the pipeline can be exercised against a realistic, stalling memory.
- Load/store size codes use RISC-V funct3 encoding, matching the existing r_sel/w_sel control signals.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array; a power of two.
- WAIT_CYCLES, 2: extra cycles between request acceptance and the memory access; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 on a clk edge resets).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_wsel  in  2  store size: 00 SB, 01 SH, 10 SW; 11 is illegal.
- req_rsel  in  3  load size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are illegal.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result, extended per rsel; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned, out of range, or illegal size code).

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - The storage array is NOT cleared.
  - An in-flight request is abandoned; a store not yet committed is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, capture we/addr/wdata/wsel/rsel.
  - Go to WAIT with counter=WAIT_CYCLES if WAIT_CYCLES>0 and the request is legal; otherwise commit and go to RESP.
- WAIT:
  - req_ready=0; counter decrements by 1 per cycle.
  - When counter==1 at an edge: commit and go to RESP.
- Commit (the single edge where the array changes or is sampled):
  - Store: write only the addressed byte lanes; all other bytes are untouched.
  - Load: select the lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW returns the whole word.
  - The result is registered into rsp_rdata.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err stay stable until the edge where rsp_ready=1; that edge returns to IDLE and clears rsp_valid.
  - No new request can be accepted in that same cycle; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Latency:
  - Acceptance edge at cycle N gives rsp_valid=1 from cycle N+WAIT_CYCLES+1, for legal requests.
  - Errors respond at N+1 regardless of WAIT_CYCLES.
- Error conditions, checked at acceptance:
  - half-word access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - word index addr[31:2] >= DEPTH_WORDS;
  - illegal wsel/rsel code.
  - On error: no array access, rsp_err=1, rsp_rdata=0.
- Inputs are ignored while req_ready=0; captured fields do not follow input changes after acceptance.
- rsp_ready held high while rsp_valid=0 has no effect.

Decomposition:
- Package dmem_pkg holds:
  - RSEL_LB/LH/LW/LBU/LHU and WSEL_SB/SH/SW localparams;
  - the state encoding (IDLE/WAIT/RESP);
  - a function returning 1 if a size code and address pair is misaligned.
- Sub-module dmem_lane_align (combinational):
  - store path: 4-bit byte-enable plus lane-replicated write data from (addr[1:0], wsel, wdata);
  - load path: extended result from (addr[1:0], rsel, word).
- The FSM, counter and array live in dmem_responder.

Test Plan:
- Reset mid-WAIT: SW 0x0000_0010 <- 0xDEADBEEF accepted, rst=0 one cycle later, then LW 0x10 -> returns the prior contents and rsp_err=0; the store was never committed.
- WAIT_CYCLES=2: SW 0x10 <- 0x8081_8283 accepted at cycle 5 -> rsp_valid first at cycle 8, rsp_rdata=0, rsp_err=0.
- Load lanes after the above store:
  - LB 0x13 -> 0xFFFF_FF80;
  - LBU 0x13 -> 0x0000_0080;
  - LH 0x12 -> 0xFFFF_8081;
  - LHU 0x10 -> 0x0000_8283;
  - LW 0x10 -> 0x8081_8283.
- Partial store: SB 0x11 <- 0x0000_00AA, then LW 0x10 -> 0x8081_AA83.
- Errors:
  - LW 0x0000_0012 -> rsp_err=1, rsp_rdata=0, response at acceptance+1;
  - LH 0x0000_0011 -> rsp_err=1;
  - SW to addr 4*DEPTH_WORDS -> rsp_err=1 and a following LW 0x0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle and a new request is accepted one cycle later.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the stalling data-memory responder.
// Size codes follow RISC-V funct3 so they line up with the core's r_sel/w_sel.
package dmem_pkg;

  localparam logic [2:0] RSEL_LB  = 3'b000;
  localparam logic [2:0] RSEL_LH  = 3'b001;
  localparam logic [2:0] RSEL_LW  = 3'b010;
  localparam logic [2:0] RSEL_LBU = 3'b100;
  localparam logic [2:0] RSEL_LHU = 3'b101;

  localparam logic [1:0] WSEL_SB  = 2'b00;
  localparam logic [1:0] WSEL_SH  = 2'b01;
  localparam logic [1:0] WSEL_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // True when the access size demands an alignment the low address bits violate.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [1:0] wsel,
                                         input logic [2:0] rsel,
                                         input logic [1:0] addr_lo);
    logic is_half;
    logic is_word;
    is_half = we ? (wsel == WSEL_SH) : ((rsel == RSEL_LH) || (rsel == RSEL_LHU));
    is_word = we ? (wsel == WSEL_SW) : (rsel == RSEL_LW);
    return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  endfunction

  function automatic logic is_illegal_size(input logic       we,
                                           input logic [1:0] wsel,
                                           input logic [2:0] rsel);
    if (we) return (wsel == 2'b11);
    return !((rsel == RSEL_LB) || (rsel == RSEL_LH) || (rsel == RSEL_LW) ||
             (rsel == RSEL_LBU) || (rsel == RSEL_LHU));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the core's right-aligned data and the 32-bit word array:
// byte enables plus replicated write data for stores, lane select and extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  wsel,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  input  logic [2:0]  rsel,
  input  logic [31:0] rword,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = '0;
    case (wsel)
      WSEL_SB: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      WSEL_SH: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      WSEL_SW: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      RSEL_LB:  rdata = {{24{rbyte[7]}}, rbyte};
      RSEL_LH:  rdata = {{16{rhalf[15]}}, rhalf};
      RSEL_LW:  rdata = rword;
      RSEL_LBU: rdata = {24'd0, rbyte};
      RSEL_LHU: rdata = {16'd0, rhalf};
      default:  ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the load/store port: one request at a time, a fixed
// number of wait states, then a held response until the core takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_wsel,
  input  logic [2:0]  req_rsel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam int         AQ_W      = IDX_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e          state;
  logic [3:0]      wait_cnt;

  logic            we_q;
  logic [AQ_W-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      wsel_q;
  logic [2:0]      rsel_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            req_err;
  logic            commit;
  logic            mem_we;
  logic            cur_we;
  logic [AQ_W-1:0] cur_addr;
  logic [31:0]     cur_wdata;
  logic [1:0]      cur_wsel;
  logic [2:0]      cur_rsel;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_lane;
  logic [31:0]     load_data;
  logic [31:0]     commit_rdata;

  assign accept = (state == ST_IDLE) && req_valid;

  // Only the request on the input pins is ever range/size checked; a captured one is already known legal.
  assign req_err = is_misaligned(req_we, req_wsel, req_rsel, req_addr[1:0]) ||
                   is_illegal_size(req_we, req_wsel, req_rsel) ||
                   (req_addr[31:AQ_W] != '0);

  // With zero wait states the access happens on the acceptance edge, straight from the pins.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr[AQ_W-1:0];
      cur_wdata = req_wdata;
      cur_wsel  = req_wsel;
      cur_rsel  = req_rsel;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_wsel  = wsel_q;
      cur_rsel  = rsel_q;
    end
  end

  assign commit = (accept && !req_err && (WAIT_CYCLES == 0)) ||
                  ((state == ST_WAIT) && (wait_cnt == 4'd1));
  // A reset edge abandons the request, so it must also suppress the write.
  assign mem_we       = rst && commit && cur_we;
  assign word_idx     = cur_addr[AQ_W-1:2];
  assign commit_rdata = cur_we ? '0 : load_data;

  dmem_lane_align u_lane_align (
    .addr_lo    (cur_addr[1:0]),
    .wsel       (cur_wsel),
    .wdata      (cur_wdata),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rsel       (cur_rsel),
    .rword      (mem[word_idx]),
    .rdata      (load_data)
  );

  // NOTE: the storage array has no reset branch; contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wsel_q    <= '0;
      rsel_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr[AQ_W-1:0];
            wdata_q   <= req_wdata;
            wsel_q    <= req_wsel;
            rsel_q    <= req_rsel;
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= commit_rdata;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= commit_rdata;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_wsel = '0;
  logic [2:0]  req_rsel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl [int unsigned];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wsel  (req_wsel),
    .req_rsel  (req_rsel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic we, input logic [1:0] wsel, input logic [2:0] rsel);
    if (we) begin
      case (wsel)
        2'd0: return 1;
        2'd1: return 2;
        2'd2: return 4;
        default: return 0;
      endcase
    end
    case (rsel)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic mdl_err(input logic we, input logic [31:0] addr,
                                   input logic [1:0] wsel, input logic [2:0] rsel);
    int n;
    n = size_bytes(we, wsel, rsel);
    if (n == 0) return 1'b1;
    if ((addr % n) != 0) return 1'b1;
    return (addr / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [2:0] rsel);
    logic [31:0] v;
    int n;
    v = '0;
    n = size_bytes(1'b0, 2'd0, rsel);
    for (int i = 0; i < n; i++) v = v | ({24'd0, mdl[addr + i]} << (8 * i));
    if (rsel == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (rsel == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] wsel);
    int n;
    n = size_bytes(1'b1, wsel, 3'd0);
    for (int i = 0; i < n; i++) mdl[addr + i] = wdata[8*i +: 8];
  endtask

  // ---------------- drivers ----------------
  // Present a request and return just after the edge that accepts it; inputs are then scrambled.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] wsel, input logic [2:0] rsel);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_wsel = wsel; req_rsel = rsel; rsp_ready = 1'b0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
    end
    @(posedge clk); #1;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_wsel = 2'($urandom); req_rsel = 3'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
    end
  endtask

  task automatic finish_rsp;
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] wsel, input logic [2:0] rsel,
                      output logic [31:0] rdata, output logic err, output int lat);
    issue(we, addr, wdata, wsel, rsel);
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    finish_rsp();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h10, 32'h1122_3344, 2'd2, 3'd0, rd, er, lat);
    mdl_store(32'h10, 32'h1122_3344, 2'd2);
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 3'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      n_bad++; $display("FAIL midwait_reset_outputs got=%b exp=100", {req_ready, rsp_valid, rsp_err});
    end
    @(negedge clk);
    rst = 1'b1;
    xfer(1'b0, 32'h10, 32'h0, 2'd0, 3'd2, rd, er, lat);
    n_cmp++; if (rd !== mdl_load(32'h10, 3'd2)) begin n_bad++; $display("FAIL midwait_reload got=%h exp=%h", rd, mdl_load(32'h10, 3'd2)); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL midwait_reload_err got=%b exp=0", er); end
  endtask

  task automatic test_latency;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h10, 32'h8081_8283, 2'd2, 3'd0, rd, er, lat);
    mdl_store(32'h10, 32'h8081_8283, 2'd2);
    n_cmp++; if (lat != WAITC) begin n_bad++; $display("FAIL store_latency got=%0d exp=%0d", lat, WAITC); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_err got=%b exp=0", er); end
  endtask

  task automatic test_lanes;
    logic [2:0]  sel [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adr [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_8283, 32'h8081_8283};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, adr[i], 32'h0, 2'd0, sel[i], rd, er, lat);
      n_cmp++;
      if (rd !== exp[i] || er !== 1'b0 || lat != WAITC) begin
        n_bad++;
        $display("FAIL lane_load_%0d got=%h/%b/%0d exp=%h/0/%0d", i, rd, er, lat, exp[i], WAITC);
      end
    end
  endtask

  task automatic test_partial_store;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h11, 32'h0000_00AA, 2'd0, 3'd0, rd, er, lat);
    mdl_store(32'h11, 32'h0000_00AA, 2'd0);
    xfer(1'b0, 32'h10, 32'h0, 2'd0, 3'd2, rd, er, lat);
    n_cmp++; if (rd !== 32'h8081_AA83) begin n_bad++; $display("FAIL partial_store got=%h exp=8081aa83", rd); end
  endtask

  task automatic test_errors;
    logic        wes [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] adr [5] = '{32'h12, 32'h11, 32'(4 * DEPTH), 32'h0, 32'h0};
    logic [1:0]  ws  [5] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd0};
    logic [2:0]  rs  [5] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd3};
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h0, 32'hCAFE_F00D, 2'd2, 3'd0, rd, er, lat);
    mdl_store(32'h0, 32'hCAFE_F00D, 2'd2);
    for (int i = 0; i < 5; i++) begin
      xfer(wes[i], adr[i], 32'h5A5A_5A5A, ws[i], rs[i], rd, er, lat);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 0) begin
        n_bad++; $display("FAIL error_case_%0d got=%b/%h/%0d exp=1/00000000/0", i, er, rd, lat);
      end
    end
    xfer(1'b0, 32'h0, 32'h0, 2'd0, 3'd2, rd, er, lat);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL error_no_write got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp; int lat;
    exp = mdl_load(32'h10, 3'd2);
    issue(1'b0, 32'h10, 32'h0, 2'd0, 3'd2);
    wait_rsp(lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cycle_%0d got=%b/%h/%b exp=1/%h/0", c, rsp_valid, rsp_rdata, req_ready, exp);
      end
    end
    finish_rsp();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL release_to_idle got=%b/%b exp=0/1", rsp_valid, req_ready);
    end
    issue(1'b0, 32'h0, 32'h0, 2'd0, 3'd2);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL next_accept got=%b exp=0", req_ready); end
    wait_rsp(lat);
    n_cmp++;
    if (rsp_rdata !== mdl_load(32'h0, 3'd2) || lat != WAITC) begin
      n_bad++; $display("FAIL next_load got=%h/%0d exp=%h/%0d", rsp_rdata, lat, mdl_load(32'h0, 3'd2), WAITC);
    end
    finish_rsp();
  endtask

  task automatic test_random;
    logic [31:0] rd, addr, wd, exp_rd; logic er, we, exp_er; logic [1:0] ws; logic [2:0] rs;
    int lat, exp_lat;
    for (int a = 0; a < 64; a += 4) begin
      wd = $urandom;
      xfer(1'b1, 32'(a), wd, 2'd2, 3'd0, rd, er, lat);
      mdl_store(32'(a), wd, 2'd2);
    end
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 63))
                                        : 32'($urandom_range(0, 63));
      wd = $urandom; ws = 2'($urandom); rs = 3'($urandom);
      exp_er  = mdl_err(we, addr, ws, rs);
      exp_rd  = (exp_er || we) ? 32'h0 : mdl_load(addr, rs);
      exp_lat = exp_er ? 0 : WAITC;
      xfer(we, addr, wd, ws, rs, rd, er, lat);
      if (we && !exp_er) mdl_store(addr, wd, ws);
      n_cmp++;
      if (rd !== exp_rd || er !== exp_er || lat != exp_lat) begin
        n_bad++;
        $display("FAIL random_%0d we=%b addr=%h ws=%0d rs=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                 i, we, addr, ws, rs, rd, er, lat, exp_rd, exp_er, exp_lat);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout sim_time=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_latency();
    test_lanes();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
